// File: rtl/lsu_pkg.sv
// Shared width codes, FSM state encoding and alignment helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_WAIT,
      ST_WR,
      ST_DONE
   } lsu_state_e;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
      case (funct3)
         F3_H, F3_HU: return lo[0];
         F3_W:        return lo != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

   // Unsigned widths exist only for loads; 011/110/111 are undefined.
   function automatic logic is_illegal(input logic [2:0] funct3, input logic write);
      return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (write && funct3[2]);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus DataMemory port of the load/store unit.
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_rdata;
   logic                  resp_err;

   logic                  memRead;
   logic                  memWrite;
   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           writeData;
   logic [31:0]           readData;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, readData,
      output req_ready, resp_valid, resp_rdata, resp_err, memRead, memWrite, address, writeData
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, readData,
      input  req_ready, resp_valid, resp_rdata, resp_err, memRead, memWrite, address, writeData
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word store data into a word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] rdata_o,
   output logic [31:0] merged_o
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word_i[{lane_i, 3'b000} +: 8];
      half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];

      rdata_o = word_i;
      case (funct3_i)
         F3_B:    rdata_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   rdata_o = {24'h0, byte_v};
         F3_H:    rdata_o = {{16{half_v[15]}}, half_v};
         F3_HU:   rdata_o = {16'h0, half_v};
         default: rdata_o = word_i;
      endcase

      merged_o = word_i;
      case (funct3_i)
         F3_B: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         F3_H: begin
            if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
            else           merged_o[15:0]  = wdata_i[15:0];
         end
         default: merged_o = wdata_i;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned DataMemory access,
// load extension and read-modify-write for byte/halfword stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_RD_WAIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   load_store_unit_if.slave bus
);
   lsu_state_e            state_q;
   logic                  write_q;
   logic [2:0]            funct3_q;
   logic [1:0]            lane_q;
   logic [31:0]           wdata_q;
   logic [1:0]            wait_cnt_q;

   logic                  memRead_q;
   logic                  memWrite_q;
   logic [ADDR_WIDTH-1:0] address_q;
   logic [31:0]           writeData_q;
   logic                  resp_valid_q;
   logic                  resp_err_q;
   logic [31:0]           resp_rdata_q;

   logic                  req_bad;
   logic                  capture;
   logic [31:0]           load_data;
   logic [31:0]           merged_data;

   assign req_bad = is_illegal(bus.req_funct3, bus.req_write) ||
                    is_misaligned(bus.req_funct3, bus.req_addr[1:0]);

   // readData is sampled on the last edge the read is held.
   assign capture = ((state_q == ST_RD) && (MEM_RD_WAIT == 0)) ||
                    ((state_q == ST_RD_WAIT) && (wait_cnt_q == 2'd0));

   lsu_lane_align u_lane_align (
      .word_i   (bus.readData),
      .wdata_i  (wdata_q),
      .lane_i   (lane_q),
      .funct3_i (funct3_q),
      .rdata_o  (load_data),
      .merged_o (merged_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         write_q      <= 1'b0;
         funct3_q     <= 3'b000;
         lane_q       <= 2'b00;
         wdata_q      <= 32'h0;
         wait_cnt_q   <= 2'd0;
         memRead_q    <= 1'b0;
         memWrite_q   <= 1'b0;
         address_q    <= '0;
         writeData_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  write_q  <= bus.req_write;
                  funct3_q <= bus.req_funct3;
                  lane_q   <= bus.req_addr[1:0];
                  wdata_q  <= bus.req_wdata;
                  if (req_bad) begin
                     state_q      <= ST_DONE;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                  end else begin
                     address_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                     if (bus.req_write && (bus.req_funct3 == F3_W)) begin
                        state_q     <= ST_WR;
                        memWrite_q  <= 1'b1;
                        writeData_q <= bus.req_wdata;
                     end else begin
                        state_q   <= ST_RD;
                        memRead_q <= 1'b1;
                     end
                  end
               end
            end

            ST_RD, ST_RD_WAIT: begin
               if (capture) begin
                  memRead_q <= 1'b0;
                  if (write_q) begin
                     state_q     <= ST_WR;
                     memWrite_q  <= 1'b1;
                     writeData_q <= merged_data;
                  end else begin
                     state_q      <= ST_DONE;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= load_data;
                  end
               end else if (state_q == ST_RD) begin
                  state_q    <= ST_RD_WAIT;
                  wait_cnt_q <= 2'(MEM_RD_WAIT - 1);
               end else begin
                  wait_cnt_q <= wait_cnt_q - 2'd1;
               end
            end

            ST_WR: begin
               memWrite_q   <= 1'b0;
               state_q      <= ST_DONE;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'h0;
            end

            ST_DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.memRead    = memRead_q;
   assign bus.memWrite   = memWrite_q;
   assign bus.address    = address_q;
   assign bus.writeData  = writeData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a byte-addressed reference memory.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk;
   logic reset;

   load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

   load_store_unit #(.ADDR_WIDTH(32), .MEM_RD_WAIT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DataMemory model: 64 words, combinational read, write on clock edge.
   logic [31:0] mem [0:63];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_dat;

   assign bus.readData = bus.memRead ? mem[bus.address[7:2]] : 32'h0BAD_F00D;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_dat;
      else if (bus.memWrite) mem[bus.address[7:2]] <= bus.writeData;
   end

   int          rd_cycles = 0;
   int          wr_pulses = 0;
   int          rd_at_wr = 0;
   int          overlap = 0;
   int          wr_long = 0;
   logic        wr_prev = 1'b0;
   logic [31:0] last_wr_addr = 32'h0;
   logic [31:0] last_wr_data = 32'h0;

   always @(posedge clk) begin
      if (bus.memRead) rd_cycles <= rd_cycles + 1;
      if (bus.memWrite) begin
         wr_pulses    <= wr_pulses + 1;
         last_wr_addr <= bus.address;
         last_wr_data <= bus.writeData;
         rd_at_wr     <= rd_cycles;
         if (wr_prev) wr_long <= wr_long + 1;
      end
      if (bus.memRead && bus.memWrite) overlap <= overlap + 1;
      wr_prev <= bus.memWrite;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%08h expected=%08h", nm, act, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] dat);
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = 6'(idx);
      pl_dat = dat;
      @(posedge clk);
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Returns at the negedge where resp_valid is first seen; lat counts edges from acceptance.
   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      n = 0;
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", 32'(n < 100), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic ack();
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   logic [7:0] ref_mem [0:255];

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
      int          sz;
      logic [31:0] v;
      sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      v  = 32'h0;
      for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      return v;
   endfunction

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      logic [31:0] wdat;
   } vec_t;

   localparam int NV = 15;
   vec_t v [NV];

   initial begin
      int lat;
      int rd0;
      int wr0;

      v[0]  = '{1'b1, 3'b010, 32'h0000_0000, 32'hAABB_CCDD, 32'h0,         1'b0, 2, 0, 1, 32'hAABB_CCDD};
      v[1]  = '{1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'hAABB_CCDD, 1'b0, 3, 2, 0, 32'h0};
      v[2]  = '{1'b1, 3'b000, 32'h0000_0005, 32'h0000_00EE, 32'h0,         1'b0, 4, 2, 1, 32'h1122_EE44};
      v[3]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'h1122_EE44, 1'b0, 3, 2, 0, 32'h0};
      v[4]  = '{1'b0, 3'b000, 32'h0000_000A, 32'h0,         32'hFFFF_FFF0, 1'b0, 3, 2, 0, 32'h0};
      v[5]  = '{1'b0, 3'b100, 32'h0000_000A, 32'h0,         32'h0000_00F0, 1'b0, 3, 2, 0, 32'h0};
      v[6]  = '{1'b0, 3'b001, 32'h0000_000A, 32'h0,         32'hFFFF_80F0, 1'b0, 3, 2, 0, 32'h0};
      v[7]  = '{1'b0, 3'b101, 32'h0000_0008, 32'h0,         32'h0000_7F01, 1'b0, 3, 2, 0, 32'h0};
      v[8]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0};
      v[9]  = '{1'b1, 3'b001, 32'h0000_0003, 32'h1234_5678, 32'h0,         1'b1, 1, 0, 0, 32'h0};
      v[10] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0};
      v[11] = '{1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 32'h0,         1'b0, 4, 2, 1, 32'hABCD_EE44};
      v[12] = '{1'b0, 3'b101, 32'h0000_0006, 32'h0,         32'h0000_ABCD, 1'b0, 3, 2, 0, 32'h0};
      v[13] = '{1'b1, 3'b100, 32'h0000_0004, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0};
      v[14] = '{1'b1, 3'b010, 32'hFFFF_FFFC, 32'h5A5A_1234, 32'h0,         1'b0, 2, 0, 1, 32'h5A5A_1234};

      reset          = 1'b0;
      pl_en          = 1'b0;
      pl_idx         = 6'd0;
      pl_dat         = 32'h0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.resp_ready = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
      chk("rst_memRead",    32'(bus.memRead),    32'd0);
      chk("rst_memWrite",   32'(bus.memWrite),   32'd0);
      chk("rst_address",    bus.address,         32'h0);
      chk("rst_writeData",  bus.writeData,       32'h0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
      chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
      reset = 1'b0;

      preload(1, 32'h1122_3344);
      preload(2, 32'h80F0_7F01);

      for (int i = 0; i < NV; i++) begin
         rd0 = rd_cycles;
         wr0 = wr_pulses;
         issue(v[i].w, v[i].f3, v[i].a, v[i].wd, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
         chk($sformatf("v%0d_rdata", i), bus.resp_rdata, v[i].rd);
         chk($sformatf("v%0d_err", i), 32'(bus.resp_err), 32'(v[i].err));
         ack();
         chk($sformatf("v%0d_rd_cycles", i), 32'(rd_cycles - rd0), 32'(v[i].nrd));
         chk($sformatf("v%0d_wr_pulses", i), 32'(wr_pulses - wr0), 32'(v[i].nwr));
         if (v[i].nwr == 1) begin
            chk($sformatf("v%0d_wr_data", i), last_wr_data, v[i].wdat);
            chk($sformatf("v%0d_wr_addr", i), last_wr_addr, v[i].a & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_rd_before_wr", i), 32'(rd_at_wr - rd0), 32'(v[i].nrd));
         end
      end

      // Backpressure: response held for 5 cycles while a second request waits.
      issue(1'b0, F3_W, 32'h8, 32'h0, lat);
      chk("bp_latency", 32'(lat), 32'd3);
      rd0 = rd_cycles;
      wr0 = wr_pulses;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'hFFFF_FFFF;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_resp_valid", k), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("bp%0d_resp_rdata", k), bus.resp_rdata, 32'h80F0_7F01);
         chk($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      chk("bp_no_read",  32'(rd_cycles - rd0), 32'd0);
      chk("bp_no_write", 32'(wr_pulses - wr0), 32'd0);
      bus.req_valid = 1'b0;
      ack();
      chk("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
      chk("bp_resp_valid_after", 32'(bus.resp_valid), 32'd0);
      issue(1'b0, F3_W, 32'h0, 32'h0, lat);
      chk("bp_next_latency", 32'(lat), 32'd3);
      chk("bp_next_rdata", bus.resp_rdata, 32'hAABB_CCDD);
      ack();

      // Asynchronous reset in the middle of an SB read phase.
      preload(1, 32'h1122_3344);
      wr0 = wr_pulses;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = F3_B;
      bus.req_addr   = 32'h5;
      bus.req_wdata  = 32'h0000_00EE;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("mr_memRead_before", 32'(bus.memRead), 32'd1);
      reset = 1'b1;
      #1;
      chk("mr_memRead_drop", 32'(bus.memRead), 32'd0);
      chk("mr_req_ready_in_reset", 32'(bus.req_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("mr_no_write", 32'(wr_pulses - wr0), 32'd0);
      chk("mr_word4", mem[1], 32'h1122_3344);
      chk("mr_req_ready", 32'(bus.req_ready), 32'd1);
      chk("mr_resp_valid", 32'(bus.resp_valid), 32'd0);

      // Randomized traffic against the byte-level reference memory.
      for (int i = 0; i < 64; i++) begin
         logic [31:0] r;
         r = $urandom;
         preload(i, r);
         for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = 8'(r >> (8 * k));
      end
      for (int i = 0; i < 60; i++) begin
         logic        w;
         logic [2:0]  f3;
         logic [31:0] wd;
         logic [31:0] er;
         logic        ee;
         int          a;
         int          sz;
         int          el;
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom_range(0, 255);
         wd = $urandom;
         sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
         if ($urandom_range(0, 3) != 0) a = a - (a % sz);
         ee = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]) || (a % sz != 0);
         if (ee) begin
            er = 32'h0;
            el = 1;
         end else if (w) begin
            er = 32'h0;
            el = (sz == 4) ? 2 : 4;
            for (int k = 0; k < sz; k++) ref_mem[a + k] = 8'(wd >> (8 * k));
         end else begin
            er = ref_load(f3, a);
            el = 3;
         end
         issue(w, f3, 32'(a), wd, lat);
         chk($sformatf("r%0d_latency", i), 32'(lat), 32'(el));
         chk($sformatf("r%0d_rdata", i), bus.resp_rdata, er);
         chk($sformatf("r%0d_err", i), 32'(bus.resp_err), 32'(ee));
         ack();
      end
      for (int i = 0; i < 64; i++) begin
         logic [31:0] exp_w;
         exp_w = {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]};
         chk($sformatf("mem_word%0d", i), mem[i], exp_w);
      end

      chk("rd_wr_overlap", 32'(overlap), 32'd0);
      chk("wr_pulse_width", 32'(wr_long), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
